// File: rtl/jop_alarm_ctrl_if.sv
// Alarm controller bus: software/counter side (master)
// and alarm controller (slave).
interface jop_alarm_ctrl_if #(
  parameter int Width      = 8,
  parameter int TimerWidth = 16,
  parameter int EvtWidth   = 8
);
  logic                  en_i;
  logic [Width-1:0]      cnt_i;
  logic [Width-1:0]      thresh_hi_i;
  logic [Width-1:0]      thresh_lo_i;
  logic [TimerWidth-1:0] decay_period_i;
  logic                  ack_i;
  logic                  evt_clr_i;
  logic                  decay_o;
  logic                  alarm_o;
  logic                  irq_o;
  logic [1:0]            state_o;
  logic [EvtWidth-1:0]   evt_cnt_o;

  modport master (
    output en_i, cnt_i, thresh_hi_i,
    output thresh_lo_i, decay_period_i,
    output ack_i, evt_clr_i,
    input  decay_o, alarm_o, irq_o,
    input  state_o, evt_cnt_o
  );

  modport slave (
    input  en_i, cnt_i, thresh_hi_i,
    input  thresh_lo_i, decay_period_i,
    input  ack_i, evt_clr_i,
    output decay_o, alarm_o, irq_o,
    output state_o, evt_cnt_o
  );
endinterface

// File: rtl/jop_alarm_ctrl.sv
// Hysteretic alarm/irq FSM with periodic decay pulses
// and a saturating alarm occurrence tally.
module jop_alarm_ctrl #(
  parameter int Width      = 8,
  parameter int TimerWidth = 16,
  parameter int EvtWidth   = 8
) (
  input logic             clk_i,
  input logic             rst_ni,
  jop_alarm_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    StDis = 2'd0,
    StArm = 2'd1,
    StAlm = 2'd2,
    StAck = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [TimerWidth-1:0] timer_q, timer_d;
  logic                  decay_q, decay_d;
  logic [EvtWidth-1:0]   evt_q, evt_d;
  logic [TimerWidth-1:0] reload;
  logic                  hit, rearm;
  logic                  evt_inc;
  logic                  per_nz;
  logic                  alarm, irq;

  assign hit    = bus.cnt_i >= bus.thresh_hi_i;
  // lo >= hi degrades to lo = hi-1
  assign rearm  = (bus.cnt_i <= bus.thresh_lo_i) && !hit;
  assign per_nz = bus.decay_period_i != '0;
  assign reload = per_nz
                ? bus.decay_period_i - TimerWidth'(1)
                : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StDis;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StDis: if (bus.en_i)  state_d = StArm;
      StArm: if (hit)       state_d = StAlm;
      StAlm: if (bus.ack_i) state_d = StAck;
      StAck: if (rearm)     state_d = StArm;
      default:              state_d = StDis;
    endcase
    if (!bus.en_i) state_d = StDis;
  end

  always_comb begin
    alarm = 1'b0;
    irq   = 1'b0;
    unique case (1'b1)
      state_q == StAlm: begin
        alarm = 1'b1;
        irq   = 1'b1;
      end
      state_q == StAck: alarm = 1'b1;
      default: ;
    endcase
  end

  assign evt_inc = bus.en_i && hit
                && (state_q == StArm);

  always_comb begin
    evt_d = evt_q;
    if (bus.evt_clr_i) begin
      evt_d = '0;
    end else if (evt_inc && evt_q != '1) begin
      evt_d = evt_q + EvtWidth'(1);
    end
  end

  // A zero period parks the timer at 0 until reload
  always_comb begin
    timer_d = timer_q;
    decay_d = 1'b0;
    if (!bus.en_i) begin
      timer_d = '0;
    end else if (state_q == StDis) begin
      timer_d = reload;
    end else if (timer_q != '0) begin
      timer_d = timer_q - TimerWidth'(1);
    end else if (per_nz) begin
      timer_d = reload;
      decay_d = bus.cnt_i != '0;
    end else begin
      timer_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_q <= '0;
      decay_q <= 1'b0;
      evt_q   <= '0;
    end else begin
      timer_q <= timer_d;
      decay_q <= decay_d;
      evt_q   <= evt_d;
    end
  end

  assign bus.decay_o   = decay_q;
  assign bus.alarm_o   = alarm;
  assign bus.irq_o     = irq;
  assign bus.state_o   = state_q;
  assign bus.evt_cnt_o = evt_q;
endmodule
